gf180mcu_fd_sc_mcu7t5v0__dffrs_pipe: RTL and testbench

Parametrised multi-bit, multi-stage register pipeline with an asynchronous active-low reset that loads a per-bit programmable initial value. It generalises the single-bit async-set flop into a WIDTH x DEPTH bank with:
- clock enable;
- synchronous clear;
- a full-bank scan chain;
- a fill/valid tracker.

It sits in the sequential cell library as a macro-level behavioural model used for pipeline retiming registers and reset-value-sensitive control pipelines.

---
 rtl/gf180mcu_fd_sc_mcu7t5v0__dffrs_pipe_pkg.sv | 16 +
 rtl/gf180mcu_fd_sc_mcu7t5v0__dffrs_pipe_if.sv | 16 +
 rtl/gf180mcu_fd_sc_mcu7t5v0__dffrs_stage.sv | 42 ++++
 rtl/gf180mcu_fd_sc_mcu7t5v0__dffrs_pipe.sv | 67 ++++++
 tb/tb_gf180mcu_fd_sc_mcu7t5v0__dffrs_pipe.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dffrs_pipe_pkg.sv
// Shared sizing helpers for the dffrs register pipeline macro.
package gf180mcu_fd_sc_mcu7t5v0__dffrs_pipe_pkg;

    localparam int unsigned DefaultWidth = 8;
    localparam int unsigned DefaultDepth = 2;

    // Fill counter must represent 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned chain_len(input int unsigned width, input int unsigned depth);
        return width * depth;
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dffrs_pipe_if.sv
// Data/control bundle of the dffrs pipeline; clock and reset stay as plain ports.
interface gf180mcu_fd_sc_mcu7t5v0__dffrs_pipe_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] D;
    logic             E;
    logic             CLR;
    logic             SE;
    logic             SI;
    logic [WIDTH-1:0] Q;
    logic             SO;
    logic             VLD;

    modport master (output D, E, CLR, SE, SI, input Q, SO, VLD);
    modport slave  (input D, E, CLR, SE, SI, output Q, SO, VLD);
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dffrs_stage.sv
// One WIDTH-bit pipeline stage: async load of INIT, scan shift, sync clear, enabled capture.
module gf180mcu_fd_sc_mcu7t5v0__dffrs_stage #(
    parameter int unsigned    WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b1}}
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             se_i,
    input  logic             clr_i,
    input  logic             e_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             si_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q;
    logic [WIDTH-1:0] stage_d;
    logic [WIDTH-1:0] shift_v;

    // Serial data enters at bit 0 and leaves from bit WIDTH-1.
    if (WIDTH == 1) begin : g_shift_bit
        assign shift_v = si_i;
    end else begin : g_shift_vec
        assign shift_v = {stage_q[WIDTH-2:0], si_i};
    end

    // Ternaries rather than if/else so an unknown control merges candidates bitwise.
    always_comb begin
        stage_d = se_i ? shift_v : (clr_i ? INIT : (e_i ? d_i : stage_q));
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            stage_q <= INIT;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_o = stage_q;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dffrs_pipe.sv
// WIDTH x DEPTH reset-value-programmable register pipeline with scan chain and fill tracker.
module gf180mcu_fd_sc_mcu7t5v0__dffrs_pipe
    import gf180mcu_fd_sc_mcu7t5v0__dffrs_pipe_pkg::*;
#(
    parameter int unsigned      WIDTH = DefaultWidth,
    parameter int unsigned      DEPTH = DefaultDepth,
    parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b1}}
) (
    input logic CLK,
    input logic RN,
    gf180mcu_fd_sc_mcu7t5v0__dffrs_pipe_if.slave bus
);

    localparam int unsigned    CntW    = cnt_width(DEPTH);
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    logic [WIDTH-1:0] stage_in [DEPTH];
    logic             stage_si [DEPTH];
    logic [WIDTH-1:0] stage_q  [DEPTH];
    logic [CntW-1:0]  cnt_q;
    logic [CntW-1:0]  cnt_d;
    logic [CntW-1:0]  cnt_inc;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign stage_in[k] = bus.D;
            assign stage_si[k] = bus.SI;
        end else begin : g_body
            assign stage_in[k] = stage_q[k-1];
            assign stage_si[k] = stage_q[k-1][WIDTH-1];
        end

        gf180mcu_fd_sc_mcu7t5v0__dffrs_stage #(
            .WIDTH (WIDTH),
            .INIT  (INIT)
        ) u_stage (
            .CLK   (CLK),
            .RN    (RN),
            .se_i  (bus.SE),
            .clr_i (bus.CLR),
            .e_i   (bus.E),
            .d_i   (stage_in[k]),
            .si_i  (stage_si[k]),
            .q_o   (stage_q[k])
        );
    end

    // Scan and clear both invalidate the pipe contents; capture saturates at DEPTH.
    always_comb begin
        cnt_inc = (cnt_q == CntFull) ? cnt_q : cnt_q + CntW'(1);
        cnt_d   = bus.SE ? {CntW{1'b0}} :
                  (bus.CLR ? {CntW{1'b0}} : (bus.E ? cnt_inc : cnt_q));
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            cnt_q <= {CntW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.Q   = stage_q[DEPTH-1];
    assign bus.SO  = stage_q[DEPTH-1][WIDTH-1];
    assign bus.VLD = (cnt_q == CntFull);

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__dffrs_pipe.sv
// Directed scoreboard bench: 8x2 INIT=A5 pipeline plus a 1x1 INIT=0 corner instance.
module tb_gf180mcu_fd_sc_mcu7t5v0__dffrs_pipe;
    import gf180mcu_fd_sc_mcu7t5v0__dffrs_pipe_pkg::*;

    localparam logic [7:0] InitA = 8'hA5;

    typedef struct {
        string      tag;
        int         sel;
        logic [9:0] val;
    } exp_t;

    logic CLK;
    logic rn_blk;
    logic rn_nba;
    logic RN;
    assign RN = rn_blk | rn_nba;

    gf180mcu_fd_sc_mcu7t5v0__dffrs_pipe_if #(.WIDTH(8)) bus_a ();
    gf180mcu_fd_sc_mcu7t5v0__dffrs_pipe_if #(.WIDTH(1)) bus_b ();

    gf180mcu_fd_sc_mcu7t5v0__dffrs_pipe #(
        .WIDTH (8),
        .DEPTH (2),
        .INIT  (InitA)
    ) dut_a (
        .CLK (CLK),
        .RN  (RN),
        .bus (bus_a)
    );

    gf180mcu_fd_sc_mcu7t5v0__dffrs_pipe #(
        .WIDTH (1),
        .DEPTH (1),
        .INIT  (1'b0)
    ) dut_b (
        .CLK (CLK),
        .RN  (RN),
        .bus (bus_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  ma0, ma1;
    int unsigned mcnt_a;
    logic        mb;
    int unsigned mcnt_b;

    task automatic model_reset();
        ma0 = InitA;
        ma1 = InitA;
        mcnt_a = 0;
        mb = 1'b0;
        mcnt_b = 0;
    endtask

    // Reference behaviour of one rising edge, using the inputs as currently driven.
    task automatic model_edge();
        if (RN !== 1'b1) begin
            model_reset();
        end else begin
            if (bus_a.SE) begin
                {ma1, ma0} = {ma1[6:0], ma0, bus_a.SI};
                mcnt_a = 0;
            end else if (bus_a.CLR) begin
                ma0 = InitA;
                ma1 = InitA;
                mcnt_a = 0;
            end else if (bus_a.E) begin
                ma1 = ma0;
                ma0 = bus_a.D;
                if (mcnt_a < 2) mcnt_a++;
            end
            if (bus_b.SE) begin
                mb = bus_b.SI;
                mcnt_b = 0;
            end else if (bus_b.CLR) begin
                mb = 1'b0;
                mcnt_b = 0;
            end else if (bus_b.E) begin
                mb = bus_b.D[0];
                mcnt_b = 1;
            end
        end
    endtask

    task automatic push_exp(input string tag);
        sb.push_back('{tag, 0, {ma1, ma1[7], mcnt_a == 2}});
        sb.push_back('{{tag, "_b"}, 1, {7'b0, mb, mb, mcnt_b == 1}});
    endtask

    task automatic check_all();
        exp_t       e;
        logic [9:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.sel == 0) obs = {bus_a.Q, bus_a.SO, bus_a.VLD};
            else            obs = {7'b0, bus_b.Q, bus_b.SO, bus_b.VLD};
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed={Q,SO,VLD}=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    // release_rn lifts reset in the NBA region of the same edge, so the edge still sees reset.
    task automatic tick(input string tag, input bit release_rn);
        model_edge();
        push_exp(tag);
        @(posedge CLK);
        if (release_rn) rn_nba <= 1'b1;
        #1;
        check_all();
    endtask

    logic [15:0] pat;

    initial begin
        pat = 16'hB2E5;
        rn_blk = 1'b0;
        rn_nba = 1'b0;
        bus_a.D = '0; bus_a.E = 1'b0; bus_a.CLR = 1'b0; bus_a.SE = 1'b0; bus_a.SI = 1'b0;
        bus_b.D = '0; bus_b.E = 1'b0; bus_b.CLR = 1'b0; bus_b.SE = 1'b0; bus_b.SI = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        push_exp("reset");
        check_all();

        @(negedge CLK);
        rn_blk = 1'b1;

        // Fill: Q=A5/VLD=0, then 3C/VLD=1, then C3.
        @(negedge CLK); bus_a.E = 1'b1; bus_a.D = 8'h3C; tick("fill1", 0);
        @(negedge CLK); bus_a.D = 8'hC3; tick("fill2", 0);
        @(negedge CLK); bus_a.D = 8'h5A; tick("fill3", 0);

        @(negedge CLK); bus_a.E = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus_a.D = 8'($urandom());
            tick("hold", 0);
            @(negedge CLK);
        end

        bus_a.CLR = 1'b1; bus_a.E = 1'b1; bus_a.D = 8'h77; tick("clr_beats_e", 0);
        @(negedge CLK); bus_a.CLR = 1'b0; bus_a.D = 8'h81; tick("refill1", 0);

        // Asynchronous assertion mid-fill must show the reset state without a clock edge.
        #2 rn_blk = 1'b0;
        model_reset();
        push_exp("async_rst");
        #1 check_all();

        @(negedge CLK); bus_a.E = 1'b1; bus_a.D = 8'hFF; tick("rel_edge", 1);
        @(negedge CLK); rn_blk = 1'b1; tick("cap_ff", 0);
        @(negedge CLK); tick("ff_out", 0);

        @(negedge CLK); bus_a.SE = 1'b1;
        for (int i = 0; i < 2 * int'(chain_len(8, 2)); i++) begin
            bus_a.SI = pat[15 - (i % 16)];
            tick("scan", 0);
            @(negedge CLK);
        end

        bus_a.CLR = 1'b1; bus_a.SI = 1'b0; tick("se_beats_clr", 0);
        @(negedge CLK); bus_a.SE = 1'b0; bus_a.CLR = 1'b0; bus_a.E = 1'b0;

        bus_b.E = 1'b1; bus_b.D = 1'b1; tick("b_cap", 0);
        @(negedge CLK); bus_b.D = 1'b0; tick("b_cap0", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
